// File: rtl/play_pkg.sv
// play_pkg: shared types and default widths for the SDRAM sample player.
// Holds the controller state enum and the default ADDR_W / DATA_W values.
package play_pkg;

  localparam int PLAY_ADDR_W = 23;
  localparam int PLAY_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ABORT = 2'd3
  } play_state_e;

endpackage

// File: rtl/play_fifo.sv
// play_fifo: show-ahead prefetch FIFO for play_stream.
// Ports: i_clk, i_rst_n; flush clears; push/wdata write; pop/rdata read
// (rdata is the head, 0 when empty); full, empty status.
module play_fifo #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_q;
  logic [AW-1:0]     rd_q;
  logic [AW:0]       cnt_q;
  logic              do_push;
  logic              do_pop;

  assign full    = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is fine when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem_q[rd_q];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push && !flush) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/play_stream.sv
// play_stream: streams play_len words from SDRAM at play_base to an
// audio valid/ready sink through a small prefetch FIFO.
// Ports: i_clk, i_rst_n (async, active-low);
//   control: play_start, play_base, play_len, play_loop, play_pause,
//            play_stop -> play_done (pulse), play_busy;
//   sdram:   play_read, play_addr, play_readdata, play_sdram_finished;
//   audio:   play_audio_valid, play_audio_data, play_audio_ready.
// Option: define PLAY_STREAM_REVERSE_EN to add play_reverse, which makes
//   a run walk downwards (base-index) instead of upwards.
module play_stream
  import play_pkg::*;
#(
  parameter int ADDR_W     = PLAY_ADDR_W,
  parameter int DATA_W     = PLAY_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              play_start,
  input  logic [ADDR_W-1:0] play_base,
  input  logic [ADDR_W-1:0] play_len,
  input  logic              play_loop,
`ifdef PLAY_STREAM_REVERSE_EN
  input  logic              play_reverse,
`endif
  input  logic              play_pause,
  input  logic              play_stop,
  output logic              play_done,
  output logic              play_busy,
  output logic              play_read,
  output logic [ADDR_W-1:0] play_addr,
  input  logic [DATA_W-1:0] play_readdata,
  input  logic              play_sdram_finished,
  output logic              play_audio_valid,
  output logic [DATA_W-1:0] play_audio_data,
  input  logic              play_audio_ready
);

  play_state_e state_q, state_d;

  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] idx_q;
  logic              loop_q;
  logic              rd_q;
  logic              done_q;

  logic ld;
  logic issue;
  logic rd_clr;
  logic done_d;
  logic last;
  logic fin;

  logic f_flush;
  logic f_push;
  logic f_pop;
  logic f_full;
  logic f_empty;

  assign fin  = rd_q && play_sdram_finished;
  assign last = (idx_q == len_q - ADDR_W'(1));

`ifdef PLAY_STREAM_REVERSE_EN
  logic rev_q;
  assign play_addr = rev_q ? base_q - idx_q : base_q + idx_q;
`else
  assign play_addr = base_q + idx_q;
`endif

  assign play_read        = rd_q;
  assign play_done        = done_q;
  assign play_busy        = (state_q != ST_IDLE);
  assign play_audio_valid = !f_empty && !play_pause;
  assign f_pop            = play_audio_valid && play_audio_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ld      = 1'b0;
    issue   = 1'b0;
    rd_clr  = 1'b0;
    done_d  = 1'b0;
    f_flush = 1'b0;
    f_push  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (play_start && !play_stop && play_len != '0) begin
          ld      = 1'b1;
          f_flush = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (play_stop) begin
          f_flush = 1'b1;
          // An unfinished read must still be completed on the bus.
          if (rd_q && !play_sdram_finished) begin
            state_d = ST_ABORT;
          end else begin
            rd_clr  = fin;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (fin) begin
          f_push = 1'b1;
          rd_clr = 1'b1;
          if (last && !loop_q) state_d = ST_DRAIN;
        end else if (!rd_q && !f_full) begin
          issue = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (play_stop) begin
          f_flush = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (f_empty) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_ABORT: begin
        if (fin) begin
          rd_clr  = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      base_q <= '0;
      len_q  <= '0;
      idx_q  <= '0;
      loop_q <= 1'b0;
      rd_q   <= 1'b0;
      done_q <= 1'b0;
`ifdef PLAY_STREAM_REVERSE_EN
      rev_q  <= 1'b0;
`endif
    end else begin
      done_q <= done_d;
      if (ld) begin
        base_q <= play_base;
        len_q  <= play_len;
        loop_q <= play_loop;
        idx_q  <= '0;
`ifdef PLAY_STREAM_REVERSE_EN
        rev_q  <= play_reverse;
`endif
      end else if (f_push) begin
        idx_q <= last ? '0 : idx_q + ADDR_W'(1);
      end
      if (issue)       rd_q <= 1'b1;
      else if (rd_clr) rd_q <= 1'b0;
    end
  end

  play_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .flush   (f_flush),
    .push    (f_push),
    .wdata   (play_readdata),
    .pop     (f_pop),
    .rdata   (play_audio_data),
    .full    (f_full),
    .empty   (f_empty)
  );

endmodule

// File: tb/tb_play_stream.sv
// tb_play_stream: self-checking bench for play_stream.
// SDRAM responder, audio sink and a queue-based reference model.
module tb_play_stream;

  localparam int AW = 23;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          play_start;
  logic [AW-1:0] play_base;
  logic [AW-1:0] play_len;
  logic          play_loop;
  logic          play_pause;
  logic          play_stop;
  logic          play_done;
  logic          play_busy;
  logic          play_read;
  logic [AW-1:0] play_addr;
  logic [DW-1:0] play_readdata;
  logic          fin;
  logic          play_audio_valid;
  logic [DW-1:0] play_audio_data;
  logic          play_audio_ready;

  always #5 clk = ~clk;

  play_stream #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .FIFO_DEPTH (4)
  ) dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .play_start          (play_start),
    .play_base           (play_base),
    .play_len            (play_len),
    .play_loop           (play_loop),
`ifdef PLAY_STREAM_REVERSE_EN
    .play_reverse        (1'b0),
`endif
    .play_pause          (play_pause),
    .play_stop           (play_stop),
    .play_done           (play_done),
    .play_busy           (play_busy),
    .play_read           (play_read),
    .play_addr           (play_addr),
    .play_readdata       (play_readdata),
    .play_sdram_finished (fin),
    .play_audio_valid    (play_audio_valid),
    .play_audio_data     (play_audio_data),
    .play_audio_ready    (play_audio_ready)
  );

  int  n_chk = 0;
  int  n_fail = 0;
  int  lat = 2;
  int  rsp_cnt = 0;
  bit  rdy_rand = 0;
  bit  rdy_fix = 1;
  bit  pause_rand = 0;
  bit  pause_fix = 0;
  int  done_cnt = 0;
  int  pause_viol = 0;
  int  addr_unstable = 0;
  bit  rd_prev = 0;
  logic [AW-1:0] start_addr = '0;
  logic [AW-1:0] comp_q[$];
  logic [DW-1:0] rx_q[$];

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] len;
    int            lat;
    bit            rdy_rand;
    logic [AW-1:0] first_a;
    logic [AW-1:0] last_a;
  } vec_t;

  function automatic logic [DW-1:0] sd_data(logic [AW-1:0] a);
    return {9'h1A5, a} ^ 32'h0055_AA00;
  endfunction

  function automatic logic [AW-1:0] exp_addr(logic [AW-1:0] b, int len,
                                             bit lp, int i);
    int k;
    k = lp ? i % len : i;
    return b + AW'(k);
  endfunction

  task automatic chk(string nm, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // SDRAM: finish each read lat cycles after it is first seen.
  initial begin
    fin = 1'b0;
    play_readdata = '0;
    forever begin
      @(negedge clk);
      if (fin) begin
        fin = 1'b0;
        rsp_cnt = 0;
        play_readdata = $urandom;
      end else if (play_read) begin
        rsp_cnt++;
        if (rsp_cnt >= lat) begin
          fin = 1'b1;
          play_readdata = sd_data(play_addr);
        end
      end else begin
        rsp_cnt = 0;
      end
    end
  end

  // Audio sink
  initial begin
    play_audio_ready = 1'b0;
    play_pause = 1'b0;
    forever begin
      @(negedge clk);
      play_audio_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
      play_pause = pause_rand ? ($urandom_range(0, 3) == 0) : pause_fix;
    end
  end

  // Observer
  initial forever begin
    @(negedge clk);
    #1;
    if (play_read && !rd_prev) start_addr = play_addr;
    rd_prev = play_read;
    if (play_read && fin) begin
      comp_q.push_back(play_addr);
      if (play_addr != start_addr) addr_unstable++;
    end
    if (play_audio_valid && play_audio_ready) rx_q.push_back(play_audio_data);
    if (play_done) done_cnt++;
    if (play_pause && play_audio_valid) pause_viol++;
  end

  task automatic start_job(logic [AW-1:0] b, logic [AW-1:0] l, bit lp);
    @(negedge clk);
    comp_q.delete();
    rx_q.delete();
    done_cnt = 0;
    pause_viol = 0;
    addr_unstable = 0;
    play_base = b;
    play_len = l;
    play_loop = lp;
    play_start = 1'b1;
    @(negedge clk);
    play_start = 1'b0;
  endtask

  task automatic wait_done(int budget);
    int k;
    k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    #3;
  endtask

  task automatic verify(string tag, logic [AW-1:0] b, int len, bit lp,
                        bit full);
    int bad;
    bad = 0;
    if (full) chk({tag, "_ncomp"}, comp_q.size(), len);
    foreach (comp_q[i]) if (comp_q[i] != exp_addr(b, len, lp, i)) bad++;
    chk({tag, "_addrs"}, bad, 0);
    bad = 0;
    foreach (rx_q[i]) if (rx_q[i] != sd_data(exp_addr(b, len, lp, i))) bad++;
    chk({tag, "_data"}, bad, 0);
    if (full) chk({tag, "_nrx"}, rx_q.size(), len);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[4];
    int   k;
    int   nrx;
    int   ncomp;

    vt[0] = '{23'h000100, 23'd3, 2, 1'b0, 23'h000100, 23'h000102};
    vt[1] = '{23'h7FFFFE, 23'd4, 2, 1'b0, 23'h7FFFFE, 23'h000001};
    vt[2] = '{23'h000ABC, 23'd1, 1, 1'b1, 23'h000ABC, 23'h000ABC};
    vt[3] = '{23'h3FFFFC, 23'd9, 3, 1'b1, 23'h3FFFFC, 23'h400004};

    rst_n = 1'b0;
    play_start = 1'b0;
    play_base = '0;
    play_len = '0;
    play_loop = 1'b0;
    play_stop = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    chk("rst_read", play_read, 0);
    chk("rst_valid", play_audio_valid, 0);
    chk("rst_done", play_done, 0);
    chk("rst_busy", play_busy, 0);
    chk("rst_addr", play_addr, 0);
    chk("rst_data", play_audio_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Ignored commands in IDLE
    done_cnt = 0;
    @(negedge clk);
    play_base = 23'h55;
    play_len = '0;
    play_start = 1'b1;
    @(negedge clk);
    play_start = 1'b0;
    #3;
    chk("len0_busy", play_busy, 0);
    play_len = 23'd4;
    play_start = 1'b1;
    play_stop = 1'b1;
    @(negedge clk);
    play_start = 1'b0;
    play_stop = 1'b0;
    #3;
    chk("startstop_busy", play_busy, 0);
    play_stop = 1'b1;
    @(negedge clk);
    play_stop = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    chk("idle_stop_done", done_cnt, 0);
    chk("idle_read", play_read, 0);

    // Directed vector table
    for (int i = 0; i < 4; i++) begin
      lat = vt[i].lat;
      rdy_rand = vt[i].rdy_rand;
      rdy_fix = 1'b1;
      start_job(vt[i].base, vt[i].len, 1'b0);
      wait_done(800);
      chk($sformatf("vec%0d_done", i), done_cnt, 1);
      chk($sformatf("vec%0d_busy", i), play_busy, 0);
      chk($sformatf("vec%0d_valid", i), play_audio_valid, 0);
      chk($sformatf("vec%0d_stable", i), addr_unstable, 0);
      chk($sformatf("vec%0d_first", i),
          comp_q.size() > 0 ? comp_q[0] : ~vt[i].first_a, vt[i].first_a);
      chk($sformatf("vec%0d_last", i),
          comp_q.size() > 0 ? comp_q[$] : ~vt[i].last_a, vt[i].last_a);
      verify($sformatf("vec%0d", i), vt[i].base, int'(vt[i].len), 0, 1);
    end
    rdy_rand = 0;

    // Sink stalled: prefetch stops at FIFO depth
    lat = 2;
    rdy_fix = 1'b0;
    start_job(23'h300, 23'd10, 1'b0);
    repeat (60) @(negedge clk);
    #3;
    chk("stall_reads", comp_q.size(), 4);
    chk("stall_read_low", play_read, 0);
    chk("stall_rx", rx_q.size(), 0);
    chk("stall_valid", play_audio_valid, 1);
    rdy_fix = 1'b1;
    wait_done(800);
    chk("stall_done", done_cnt, 1);
    verify("stall", 23'h300, 10, 0, 1);

    // Long pause mid-stream
    lat = 1;
    start_job(23'h500, 23'd12, 1'b0);
    k = 0;
    while (rx_q.size() < 2 && k < 200) begin
      @(negedge clk);
      k++;
    end
    pause_fix = 1'b1;
    repeat (22) @(negedge clk);
    #3;
    chk("pause_valid", play_audio_valid, 0);
    chk("pause_fill", comp_q.size() - rx_q.size(), 4);
    chk("pause_viol", pause_viol, 0);
    pause_fix = 1'b0;
    wait_done(800);
    chk("pause_done", done_cnt, 1);
    verify("pause", 23'h500, 12, 0, 1);

    // Stop with a read outstanding
    lat = 6;
    start_job(23'h600, 23'd8, 1'b0);
    k = 0;
    do begin
      @(negedge clk);
      #3;
      k++;
    end while (!(comp_q.size() >= 2 && play_read && rsp_cnt == 1) && k < 300);
    play_stop = 1'b1;
    @(negedge clk);
    play_stop = 1'b0;
    #3;
    chk("abort_read_held", play_read, 1);
    chk("abort_busy", play_busy, 1);
    chk("abort_valid", play_audio_valid, 0);
    ncomp = comp_q.size();
    nrx = rx_q.size();
    wait_done(300);
    chk("abort_comp", comp_q.size(), ncomp + 1);
    chk("abort_rx", rx_q.size(), nrx);
    chk("abort_done", done_cnt, 1);
    chk("abort_idle", play_busy, 0);
    verify("abort", 23'h600, 8, 0, 0);
    lat = 2;
    start_job(23'h600, 23'd2, 1'b0);
    wait_done(300);
    chk("restart_done", done_cnt, 1);
    verify("restart", 23'h600, 2, 0, 1);

    // Stop on the same edge as the read finishing
    lat = 3;
    start_job(23'h700, 23'd5, 1'b0);
    k = 0;
    do begin
      @(negedge clk);
      #3;
      k++;
    end while (!(fin && comp_q.size() >= 2) && k < 300);
    play_stop = 1'b1;
    @(negedge clk);
    play_stop = 1'b0;
    #3;
    chk("coin_idle", play_busy, 0);
    chk("coin_done", done_cnt, 1);
    chk("coin_read", play_read, 0);
    chk("coin_valid", play_audio_valid, 0);
    nrx = rx_q.size();
    repeat (5) @(negedge clk);
    #3;
    chk("coin_rx", rx_q.size(), nrx);
    chk("coin_done2", done_cnt, 1);
    verify("coin", 23'h700, 5, 0, 0);

    // Loop mode until stopped
    lat = 1;
    rdy_rand = 1;
    start_job(23'h10, 23'd2, 1'b1);
    repeat (80) @(negedge clk);
    #3;
    chk("loop_nodone", done_cnt, 0);
    chk("loop_busy", play_busy, 1);
    chk("loop_many", comp_q.size() >= 6, 1);
    verify("loop", 23'h10, 2, 1, 0);
    @(negedge clk);
    play_stop = 1'b1;
    @(negedge clk);
    play_stop = 1'b0;
    wait_done(300);
    chk("loop_done", done_cnt, 1);
    chk("loop_idle", play_busy, 0);
    rdy_rand = 0;

    // Reset during a read
    lat = 5;
    start_job(23'h800, 23'd4, 1'b0);
    k = 0;
    do begin
      @(negedge clk);
      #3;
      k++;
    end while (!(play_read && rsp_cnt == 1) && k < 200);
    rst_n = 1'b0;
    #1;
    chk("mrst_read", play_read, 0);
    chk("mrst_busy", play_busy, 0);
    chk("mrst_valid", play_audio_valid, 0);
    chk("mrst_done", play_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #3;
    chk("mrst_nodone", done_cnt, 0);
    chk("mrst_idle", play_busy, 0);

    // Randomized runs against the model
    for (int j = 0; j < 10; j++) begin
      logic [AW-1:0] b;
      int            l;
      b = (j % 3 == 0) ? AW'(23'h7FFFF8 + $urandom_range(0, 7))
                       : AW'($urandom);
      l = $urandom_range(1, 12);
      lat = $urandom_range(1, 4);
      rdy_rand = 1;
      pause_rand = (j % 2 == 1);
      start_job(b, AW'(l), 1'b0);
      // A second start while busy must be ignored.
      @(negedge clk);
      play_base = AW'($urandom);
      play_len = 23'd5;
      play_start = 1'b1;
      @(negedge clk);
      play_start = 1'b0;
      wait_done(3000);
      chk($sformatf("rnd%0d_done", j), done_cnt, 1);
      chk($sformatf("rnd%0d_idle", j), play_busy, 0);
      chk($sformatf("rnd%0d_pause", j), pause_viol, 0);
      chk($sformatf("rnd%0d_stable", j), addr_unstable, 0);
      verify($sformatf("rnd%0d", j), b, l, 0, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/play_stream.md
PLAY_STREAM -- requirements
Module: play_stream

Interface
REQ-001 SHALL have parameter ADDR_W, 23, SDRAM word-address width.
REQ-002 SHALL have parameter DATA_W, 32, sample word width.
REQ-003 SHALL have parameter FIFO_DEPTH, 4, prefetch FIFO depth in words (power of two, >=2).
REQ-004 SHALL have port i_clk  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port i_rst_n  in  1  reset; asynchronous, active-low.
REQ-006 SHALL have ports play_start in 1 start pulse; play_base in ADDR_W first address; play_len in ADDR_W word count; play_loop in 1 loop mode.
REQ-007 SHALL have ports play_pause in 1 level pause; play_stop in 1 abort pulse; play_done out 1 completion pulse; play_busy out 1 not idle.
REQ-008 SHALL have ports play_read out 1; play_addr out ADDR_W; play_readdata in DATA_W; play_sdram_finished in 1.
REQ-009 SHALL have ports play_audio_valid out 1; play_audio_data out DATA_W; play_audio_ready in 1.

Function
REQ-010 SHALL implement states IDLE, FETCH, DRAIN, ABORT.
REQ-011 IDLE: play_start with play_len!=0 SHALL latch base/len/loop, clear FIFO and index, go FETCH; play_len==0 SHALL be ignored.
REQ-012 play_start while not IDLE SHALL be ignored.
REQ-013 FETCH SHALL assert play_read only when FIFO has a free slot, holding play_addr stable until play_sdram_finished.
REQ-014 On play_sdram_finished, play_readdata SHALL be pushed the same edge and index incremented; next read may start the following cycle.
REQ-015 play_addr SHALL equal base+index modulo 2^ADDR_W (wrap past top address allowed).
REQ-016 After len words fetched: play_loop=0 SHALL go DRAIN; play_loop=1 SHALL reset index to 0 and stay FETCH.
REQ-017 DRAIN SHALL issue no reads; when FIFO empty SHALL go IDLE and pulse play_done one cycle.
REQ-018 play_audio_valid SHALL equal FIFO-not-empty AND NOT play_pause; play_audio_data SHALL be FIFO head (show-ahead).
REQ-019 FIFO pop SHALL occur on valid&&ready; simultaneous push and pop on full FIFO SHALL be legal, count unchanged.
REQ-020 play_pause SHALL not stop prefetch; fetching continues until FIFO full.
REQ-021 play_stop in FETCH/DRAIN SHALL flush FIFO next edge; with a read outstanding SHALL go ABORT, holding play_read until finished and discarding that data, then IDLE; otherwise go IDLE directly; play_done SHALL pulse on entering IDLE.
REQ-022 play_stop coincident with play_sdram_finished SHALL discard the data and go IDLE directly.
REQ-023 play_stop and play_start in the same cycle: stop SHALL win; stop in IDLE SHALL be ignored.
REQ-024 play_busy SHALL be 1 in every state except IDLE.

Reset
REQ-025 Reset SHALL force IDLE, empty FIFO, index 0, and play_read, play_audio_valid, play_done, play_busy, play_addr, play_audio_data all 0.
REQ-026 Reset mid-transaction SHALL drop play_read immediately without completing it or pulsing play_done.

Configuration
REQ-027 With PLAY_STREAM_REVERSE_EN defined, port play_reverse (in 1) SHALL exist, be latched at start, and when 1 give play_addr = base-index modulo 2^ADDR_W.
REQ-028 Without PLAY_STREAM_REVERSE_EN, port play_reverse SHALL not exist and addressing SHALL be forward only.

Structure
REQ-029 Package play_pkg SHALL hold the state enum and default ADDR_W/DATA_W constants.
REQ-030 Prefetch storage SHALL be sub-module play_fifo (parametrised DATA_W, FIFO_DEPTH, push/pop/full/empty/flush).

Verification
REQ-031 base=0x100, len=3, SDRAM finishes 2 cycles after read, ready=1 -> addrs 0x100,0x101,0x102; three samples in order; one play_done pulse; busy low after.
REQ-032 base=0x7FFFFE, len=4 -> addrs 0x7FFFFE,0x7FFFFF,0x000000,0x000001.
REQ-033 ready=0, FIFO_DEPTH=4, len=10 -> exactly 4 reads complete, play_read then stays 0 until first pop.
REQ-034 pause=1 for 20 cycles mid-stream -> valid 0 throughout, FIFO fills to 4, no sample lost or duplicated after release.
REQ-035 stop while read outstanding -> play_read held to finished, data not delivered, valid 0 next cycle, one play_done, next start restarts at base.
REQ-036 loop=1, len=2, base=0x10 -> addrs 0x10,0x11,0x10,0x11,... until stop; no play_done before stop.
